// File: rtl/label_stack_pkg.sv
// label_stack_pkg: op, label-kind, trap and FSM state codes shared by label_stack and the cpu.
package label_stack_pkg;
  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_BR, OP_CLEAR} op_e;
  typedef enum logic [1:0] {KIND_BLOCK, KIND_LOOP, KIND_IF} kind_e;
  typedef enum logic [1:0] {TRAP_NONE, TRAP_OVERFLOW, TRAP_UNDERFLOW} trap_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP, S_TRAP} state_e;
endpackage

// File: rtl/label_stack_ram.sv
// label_ram: label storage, one write port and one registered read port.
module label_ram #(
  parameter int W = 18,
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic [DEPTH_LOG-1:0] raddr,
  output logic [W-1:0]         rdata
);
  logic [W-1:0] mem [2**DEPTH_LOG];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/label_stack.sv
// label_stack: structured-control label stack resolving POP/BR targets; LABEL_STACK_HWM_EN adds the hwm output.
module label_stack
  import label_stack_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int SP_W = 8,
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [1:0]           op,
  input  logic [1:0]           op_kind,
  input  logic [ADDR_W-1:0]    op_addr,
  input  logic [SP_W-1:0]      op_sp,
  input  logic [DEPTH_LOG:0]   op_n,
  output logic                 res_valid,
  output logic [ADDR_W-1:0]    res_addr,
  output logic [SP_W-1:0]      res_sp,
  output logic [DEPTH_LOG:0]   count,
  output logic [1:0]           trap
`ifdef LABEL_STACK_HWM_EN
  ,
  output logic [DEPTH_LOG:0]   hwm
`endif
);
  localparam int W = 2 + ADDR_W + SP_W;
  localparam int CW = DEPTH_LOG + 1;
  localparam logic [CW-1:0] FULL = CW'(2**DEPTH_LOG);
  state_e state, state_nx;
  logic [CW-1:0] count_nx, n_q, n_nx;
  logic [1:0] trap_nx, rd_kind;
  logic pop_q, pop_nx, res_valid_nx, we, clr, keep;
  logic [ADDR_W-1:0] res_addr_nx, rd_addr;
  logic [SP_W-1:0] res_sp_nx, rd_sp;
  logic [W-1:0] rdata;
  label_ram #(.W(W), .DEPTH_LOG(DEPTH_LOG)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(count[DEPTH_LOG-1:0]),
    .wdata({op_kind, op_addr, op_sp}),
    .raddr(count[DEPTH_LOG-1:0] - n_q[DEPTH_LOG-1:0] - DEPTH_LOG'(1)),
    .rdata(rdata)
  );
  assign {rd_kind, rd_addr, rd_sp} = rdata;
  // a BR landing on a LOOP keeps the label; POP always discards it
  assign keep = !pop_q && rd_kind == KIND_LOOP;
  assign clr = op_valid && op == OP_CLEAR && (state == S_IDLE || state == S_TRAP);
  always_comb begin
    state_nx = state;
    count_nx = count;
    trap_nx = trap;
    n_nx = n_q;
    pop_nx = pop_q;
    res_valid_nx = 1'b0;
    res_addr_nx = res_addr;
    res_sp_nx = res_sp;
    we = 1'b0;
    op_ready = state == S_IDLE;
    if (clr) begin
      count_nx = '0;
      trap_nx = TRAP_NONE;
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (op_valid) begin
          if (op == OP_PUSH) begin
            we = count != FULL;
            count_nx = we ? count + CW'(1) : count;
            trap_nx = we ? trap : TRAP_OVERFLOW;
            state_nx = we ? S_IDLE : S_TRAP;
          end else begin
            pop_nx = op == OP_POP;
            n_nx = pop_nx ? '0 : op_n;
            trap_nx = n_nx >= count ? TRAP_UNDERFLOW : trap;
            state_nx = n_nx >= count ? S_TRAP : S_READ;
          end
        end
        S_READ: state_nx = S_RESP;
        S_RESP: begin
          res_valid_nx = 1'b1;
          res_addr_nx = rd_addr;
          res_sp_nx = rd_sp;
          count_nx = count - n_q - {{DEPTH_LOG{1'b0}}, ~keep};
          state_nx = S_IDLE;
        end
        default: state_nx = S_TRAP;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      count <= '0;
      trap <= TRAP_NONE;
      n_q <= '0;
      pop_q <= 1'b0;
      res_valid <= 1'b0;
      res_addr <= '0;
      res_sp <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      trap <= trap_nx;
      n_q <= n_nx;
      pop_q <= pop_nx;
      res_valid <= res_valid_nx;
      res_addr <= res_addr_nx;
      res_sp <= res_sp_nx;
    end
  end
`ifdef LABEL_STACK_HWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm <= '0;
    else if (clr) hwm <= '0;
    else if (count_nx > hwm) hwm <= count_nx;
  end
`endif
endmodule

// File: tb/tb_label_stack.sv
// tb_label_stack: randomized and directed checks of label_stack against a queue-based label model.
module tb_label_stack;
  import label_stack_pkg::*;
  localparam int DEPTH = 8;
  logic clk = 0, rst_n = 0, op_valid = 0;
  logic [1:0] op = 0, op_kind = 0;
  logic [7:0] op_addr = 0, op_sp = 0;
  logic [3:0] op_n = 0;
  logic op_ready, res_valid;
  logic [7:0] res_addr, res_sp;
  logic [3:0] count;
  logic [1:0] trap;
`ifdef LABEL_STACK_HWM_EN
  logic [3:0] hwm;
`endif
  label_stack dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .op_kind(op_kind), .op_addr(op_addr), .op_sp(op_sp), .op_n(op_n),
    .res_valid(res_valid), .res_addr(res_addr), .res_sp(res_sp), .count(count), .trap(trap)
`ifdef LABEL_STACK_HWM_EN
    , .hwm(hwm)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int kind;
    int addr;
    int sp;
  } ent_t;
  ent_t stk[$];
  int m_trap = 0, m_addr = 0, m_sp = 0, m_hwm = 0;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), stk.size());
    check({tag, ".trap"}, 32'(trap), m_trap);
    check({tag, ".ready"}, 32'(op_ready), 32'(m_trap == 0));
    check({tag, ".res_addr"}, 32'(res_addr), m_addr);
    check({tag, ".res_sp"}, 32'(res_sp), m_sp);
`ifdef LABEL_STACK_HWM_EN
    check({tag, ".hwm"}, 32'(hwm), m_hwm);
`endif
  endtask
  task automatic drive(input op_e o, input int k, input int a, input int s, input int n);
    @(negedge clk);
    op_valid = 1;
    op = o;
    op_kind = 2'(k);
    op_addr = 8'(a);
    op_sp = 8'(s);
    op_n = 4'(n);
    @(negedge clk);
    op_valid = 0;
  endtask
  task automatic do_push(input int k, input int a, input int s);
    drive(OP_PUSH, k, a, s, 0);
    if (m_trap == 0) begin
      if (stk.size() == DEPTH) m_trap = 1;
      else begin
        stk.push_back('{k, a, s});
        if (stk.size() > m_hwm) m_hwm = stk.size();
      end
    end
    check("push.rv", 32'(res_valid), 0);
    check_state("push");
  endtask
  task automatic do_br(input bit is_pop, input int n);
    int eff, newsz;
    ent_t e;
    bit idle;
    idle = m_trap == 0;
    eff = is_pop ? 0 : n;
    drive(is_pop ? OP_POP : OP_BR, 0, 0, 0, n);
    if (!idle) begin
      check("ign.rv", 32'(res_valid), 0);
      check_state("ign");
      return;
    end
    if (eff >= stk.size()) begin
      m_trap = 2;
      check_state("uf");
      repeat (3) begin
        @(negedge clk);
        check("uf.rv", 32'(res_valid), 0);
      end
      check_state("uf.hold");
      return;
    end
    e = stk[stk.size() - 1 - eff];
    newsz = stk.size() - eff - ((!is_pop && e.kind == 1) ? 0 : 1);
    while (stk.size() > newsz) void'(stk.pop_back());
    check("br.busy", 32'(op_ready), 0);
    @(negedge clk);
    check("br.rv_early", 32'(res_valid), 0);
    @(negedge clk);
    check("br.rv", 32'(res_valid), 1);
    m_addr = e.addr;
    m_sp = e.sp;
    check_state("br");
    @(negedge clk);
    check("br.rv_pulse", 32'(res_valid), 0);
    check_state("br.hold");
  endtask
  task automatic do_clear();
    drive(OP_CLEAR, 0, 0, 0, 0);
    stk.delete();
    m_trap = 0;
    m_hwm = 0;
    check_state("clear");
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    #1;
    check("rst.rv", 32'(res_valid), 0);
    check_state("rst");
    repeat (2) @(negedge clk);
    rst_n = 1;
    do_push(0, 'h10, 3);
    do_push(1, 'h20, 5);
    do_br(0, 0);
    check("br0.count", 32'(count), 2);
    check("br0.addr", 32'(res_addr), 'h20);
    do_clear();
    do_push(0, 'h10, 3);
    do_push(1, 'h20, 5);
    do_br(0, 1);
    check("br1.count", 32'(count), 0);
    check("br1.sp", 32'(res_sp), 3);
    for (int i = 0; i < 9; i++) do_push(i % 3, i, i + 1);
    check("ovf.trap", 32'(trap), 1);
    check("ovf.count", 32'(count), 8);
    do_push(0, 1, 1);
    do_br(1, 0);
    do_clear();
    do_push(2, 'h33, 7);
    do_br(0, 1);
    check("uf.count", 32'(count), 1);
    do_clear();
    do_push(1, 'h44, 9);
    drive(OP_BR, 0, 0, 0, 0);
    rst_n = 0;
    #1;
    stk.delete();
    m_trap = 0;
    m_addr = 0;
    m_sp = 0;
    m_hwm = 0;
    check("arst.rv", 32'(res_valid), 0);
    check_state("arst");
    @(negedge clk);
    rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      check("arst.norv", 32'(res_valid), 0);
    end
    check_state("arst.after");
    for (int i = 0; i < 5; i++) do_push(0, i + 1, i);
    for (int i = 0; i < 3; i++) do_br(1, 0);
`ifdef LABEL_STACK_HWM_EN
    check("hwm.val", 32'(hwm), 5);
`endif
    check("hwm.count", 32'(count), 2);
    do_clear();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(99);
      if (m_trap != 0 && r < 60) do_clear();
      else if (r < 45) do_push($urandom_range(2), $urandom_range(255), $urandom_range(255));
      else if (r < 65) do_br(1, $urandom_range(15));
      else if (r < 92) do_br(0, $urandom_range(stk.size() + 1));
      else do_clear();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/label_stack.md
LABEL_STACK -- requirements
Module: label_stack

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the width of code addresses held per label.
REQ-002 Parameter SP_W, default 8, SHALL set the width of the saved value-stack height per label.
REQ-003 Parameter DEPTH_LOG, default 3, SHALL size the store to 2**DEPTH_LOG labels.
REQ-004 clk  input  1  SHALL be the single clock; all state on rising edge.
REQ-005 reset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 op_valid  input  1  SHALL qualify op, op_kind, op_addr, op_sp, op_n.
REQ-007 op_ready  output  1  SHALL be high only in IDLE.
REQ-008 op  input  2  SHALL select PUSH, POP, BR or CLEAR.
REQ-009 op_kind  input  2  SHALL give the label kind for PUSH: BLOCK, LOOP or IF.
REQ-010 op_addr  input  ADDR_W  SHALL be the branch target stored by PUSH.
REQ-011 op_sp  input  SP_W  SHALL be the value-stack height stored by PUSH.
REQ-012 op_n  input  DEPTH_LOG+1  SHALL be the relative label index for BR.
REQ-013 res_valid  output  1  SHALL pulse one cycle per completed POP/BR.
REQ-014 res_addr, res_sp  output  ADDR_W, SP_W  SHALL carry the resolved target and height.
REQ-015 count  output  DEPTH_LOG+1  SHALL report the current number of labels.
REQ-016 trap  output  2  SHALL report NONE, OVERFLOW or UNDERFLOW; sticky until reset or CLEAR.

Function
REQ-017 An op SHALL be accepted only when op_valid and op_ready are both high in the same cycle.
REQ-018 The FSM SHALL have states IDLE, READ, RESP and TRAP; accepted POP/BR moves IDLE->READ->RESP->IDLE.
REQ-019 PUSH SHALL store {kind, addr, sp} at index count, increment count and stay in IDLE (1-cycle throughput).
REQ-020 PUSH when count == 2**DEPTH_LOG SHALL leave storage unchanged, set trap=OVERFLOW and enter TRAP.
REQ-021 BR n SHALL read entry count-1-n in READ; result is registered, so res_valid rises 2 cycles after acceptance.
REQ-022 BR to a LOOP entry SHALL set count to count-n (loop label kept); BR to BLOCK/IF SHALL set count to count-n-1.
REQ-023 POP SHALL behave as BR 0 to a BLOCK irrespective of the stored kind.
REQ-024 POP or BR with n >= count SHALL leave count unchanged, suppress res_valid, set trap=UNDERFLOW and enter TRAP.
REQ-025 TRAP SHALL hold op_ready low; only CLEAR (accepted in TRAP) or reset SHALL leave it.
REQ-026 CLEAR SHALL set count=0 and trap=NONE in one cycle from IDLE or TRAP.
REQ-027 res_addr/res_sp SHALL hold their last value while res_valid is low.

Reset
REQ-028 Reset low SHALL immediately force IDLE, count=0, trap=NONE, res_valid=0, res_addr=0, res_sp=0; storage contents are don't-care.
REQ-029 Reset asserted mid-READ/RESP SHALL abort the op with no res_valid pulse after release.

Configuration
REQ-030 With LABEL_STACK_HWM_EN defined, an extra output hwm (DEPTH_LOG+1) SHALL track the maximum count since reset/CLEAR; without it, the port and register SHALL not exist.

Structure
REQ-031 Op codes, kind codes and trap codes SHALL live in shared package label_stack_pkg, reused by cpu.
REQ-032 Storage SHALL be sub-module label_ram (1 write, 1 registered read port, 2**DEPTH_LOG x (2+ADDR_W+SP_W)).

Verification
REQ-033 PUSH BLOCK(0x10,3), PUSH LOOP(0x20,5), BR 0 -> res_addr=0x20, res_sp=5, count=2.
REQ-034 Same pushes, BR 1 -> res_addr=0x10, res_sp=3, count=0.
REQ-035 DEPTH_LOG=3: 9 PUSHes -> 9th sets trap=OVERFLOW, count=8, op_ready=0; CLEAR -> count=0, trap=NONE.
REQ-036 count=1, BR 1 -> trap=UNDERFLOW, no res_valid, count=1.
REQ-037 Reset low during READ of BR 0 -> no res_valid, count=0 after release.
REQ-038 LABEL_STACK_HWM_EN: PUSH x5, POP x3 -> hwm=5, count=2.
